mem_refill: RTL and testbench

Line-refill engine for the CGRA L1 data cache. It accepts a miss request carrying the line address and the victim way. It fetches the 512-bit line from the next-level bus as eight 64-bit beats and writes each beat into the data memory through that memory's single-port write interface. It sits directly upstream of the data memory, shares its mem_en/rd_wr/addr/data_in/way_index port group, and pulses done once the whole line is resident.

---
 rtl/mem_refill_if.sv | 37 +++
 rtl/mem_refill.sv | 147 ++++++++++++++
 tb/tb_mem_refill.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_refill_if.sv
// Port bundle for the mem_refill line-refill engine: request, next-level bus,
// data-memory write group and status. master = engine side, slave = environment side.
interface mem_refill_if #(
  parameter int unsigned DATA_WDT = 64
);
  logic                req_valid;
  logic                req_ready;
  logic [31:0]         req_addr;
  logic [2:0]          req_way;
  logic                bus_rd_valid;
  logic                bus_rd_ready;
  logic [31:0]         bus_rd_addr;
  logic                bus_data_valid;
  logic                bus_data_ready;
  logic [DATA_WDT-1:0] bus_data;
  logic                mem_en;
  logic                rd_wr;
  logic [31:0]         addr;
  logic [DATA_WDT-1:0] data_in;
  logic [2:0]          way_index;
  logic                crit_valid;
  logic [DATA_WDT-1:0] crit_data;
  logic                done;
  logic                busy;

  modport master (
    input  req_valid, req_addr, req_way, bus_rd_ready, bus_data_valid, bus_data,
    output req_ready, bus_rd_valid, bus_rd_addr, bus_data_ready,
           mem_en, rd_wr, addr, data_in, way_index, crit_valid, crit_data, done, busy
  );

  modport slave (
    output req_valid, req_addr, req_way, bus_rd_ready, bus_data_valid, bus_data,
    input  req_ready, bus_rd_valid, bus_rd_addr, bus_data_ready,
           mem_en, rd_wr, addr, data_in, way_index, crit_valid, crit_data, done, busy
  );
endinterface

// File: rtl/mem_refill.sv
// L1 data-cache line-refill engine: fetches eight beats and writes them into the data memory.
// Define REFILL_CRIT_FIRST_EN to request the critical word first with wrapping beat order.
module mem_refill #(
  parameter int unsigned DATA_WDT = 64
) (
  input  logic          clk,
  input  logic          rst,
  mem_refill_if.master  io
);

  localparam int unsigned BEATS  = 8;
  localparam int unsigned CNT_W  = 3;
  localparam int unsigned LINE_W = 26;

`ifdef REFILL_CRIT_FIRST_EN
  localparam bit CRIT_FIRST = 1'b1;
`else
  localparam bit CRIT_FIRST = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, REQ, FILL, DONE} state_e;

  state_e              state_q;
  logic [LINE_W-1:0]   line_q;
  logic [CNT_W-1:0]    crit_idx_q;
  logic [CNT_W-1:0]    start_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [2:0]          way_q;
  logic                req_ready_q;
  logic                bus_rd_valid_q;
  logic [31:0]         bus_rd_addr_q;
  logic                bus_data_ready_q;
  logic                done_q;
  logic                busy_q;
  logic                wr_vld_q;
  logic [31:0]         wr_addr_q;
  logic [DATA_WDT-1:0] wr_data_q;
  logic [2:0]          wr_way_q;
  logic                crit_vld_q;
  logic [DATA_WDT-1:0] crit_data_q;

  logic                beat_acc_c;
  logic [CNT_W-1:0]    widx_c;
  logic                unused_addr_lsb_c;

  // bus_data_ready_q is only high in FILL, so this is the accepted-beat strobe
  assign beat_acc_c        = bus_data_ready_q && io.bus_data_valid;
  assign widx_c            = start_q + cnt_q;
  assign unused_addr_lsb_c = ^io.req_addr[2:0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q          <= IDLE;
      line_q           <= '0;
      crit_idx_q       <= '0;
      start_q          <= '0;
      cnt_q            <= '0;
      way_q            <= '0;
      req_ready_q      <= 1'b1;
      bus_rd_valid_q   <= 1'b0;
      bus_rd_addr_q    <= '0;
      bus_data_ready_q <= 1'b0;
      done_q           <= 1'b0;
      busy_q           <= 1'b0;
      wr_vld_q         <= 1'b0;
      wr_addr_q        <= '0;
      wr_data_q        <= '0;
      wr_way_q         <= '0;
      crit_vld_q       <= 1'b0;
      crit_data_q      <= '0;
    end else begin
      wr_vld_q   <= 1'b0;
      crit_vld_q <= 1'b0;
      done_q     <= 1'b0;

      // One-entry write stage: every accepted beat is written the following cycle
      if (beat_acc_c) begin
        wr_vld_q  <= 1'b1;
        wr_addr_q <= {3'b000, line_q, widx_c};
        wr_data_q <= io.bus_data;
        wr_way_q  <= way_q;
        cnt_q     <= cnt_q + CNT_W'(1);
        if (widx_c == crit_idx_q) begin
          crit_vld_q  <= 1'b1;
          crit_data_q <= io.bus_data;
        end
      end

      case (state_q)
        IDLE: begin
          if (io.req_valid) begin
            line_q         <= io.req_addr[31:6];
            crit_idx_q     <= io.req_addr[5:3];
            start_q        <= CRIT_FIRST ? io.req_addr[5:3] : CNT_W'(0);
            bus_rd_addr_q  <= CRIT_FIRST ? {io.req_addr[31:3], 3'b000}
                                         : {io.req_addr[31:6], 6'b000000};
            way_q          <= io.req_way;
            cnt_q          <= '0;
            req_ready_q    <= 1'b0;
            busy_q         <= 1'b1;
            bus_rd_valid_q <= 1'b1;
            state_q        <= REQ;
          end
        end
        REQ: begin
          if (io.bus_rd_ready) begin
            bus_rd_valid_q   <= 1'b0;
            bus_data_ready_q <= 1'b1;
            state_q          <= FILL;
          end
        end
        FILL: begin
          if (beat_acc_c && (cnt_q == CNT_W'(BEATS - 1))) begin
            bus_data_ready_q <= 1'b0;
            state_q          <= DONE;
          end
        end
        DONE: begin
          // First DONE cycle drains the last write; done pulses on the second
          if (!done_q) begin
            done_q <= 1'b1;
          end else begin
            req_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign io.req_ready      = req_ready_q;
  assign io.bus_rd_valid   = bus_rd_valid_q;
  assign io.bus_rd_addr    = bus_rd_addr_q;
  assign io.bus_data_ready = bus_data_ready_q;
  assign io.mem_en         = wr_vld_q;
  assign io.rd_wr          = wr_vld_q;
  assign io.addr           = wr_addr_q;
  assign io.data_in        = wr_data_q;
  assign io.way_index      = wr_way_q;
  assign io.crit_valid     = crit_vld_q;
  assign io.crit_data      = crit_data_q;
  assign io.done           = done_q;
  assign io.busy           = busy_q;

endmodule

// File: tb/tb_mem_refill.sv
// Randomized bench for mem_refill against a transaction-level model of the refill rules.
module tb_mem_refill;

  localparam int unsigned DATA_WDT = 64;
  localparam int unsigned N_TXN    = 40;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  mem_refill_if #(.DATA_WDT(DATA_WDT)) io ();

  mem_refill #(.DATA_WDT(DATA_WDT)) dut (
    .clk (clk),
    .rst (rst),
    .io  (io.master)
  );

  typedef struct {
    int          cyc;
    logic [31:0] addr;
    logic [63:0] data;
    logic [2:0]  way;
    bit          crit;
  } wr_t;

  wr_t wr_q[$];
  wr_t e;
  bit  due;
  int  total = 0;
  int  bad = 0;
  int  cyc = 0;
  int  exp_done = -1;
  int  last_done = -1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Write-port and done monitor against the expected-write queue
  always @(negedge clk) begin
    if (rst) begin
      due = (wr_q.size() > 0) && (wr_q[0].cyc <= cyc);
      if (io.mem_en || due) begin
        check("mem_en", 64'(io.mem_en), 64'd1);
        check("wr_on_time", 64'(due), 64'd1);
        if (wr_q.size() > 0) begin
          e = wr_q.pop_front();
          check("wr_addr", 64'(io.addr), 64'(e.addr));
          check("wr_data", io.data_in, e.data);
          check("wr_way", 64'(io.way_index), 64'(e.way));
          check("rd_wr", 64'(io.rd_wr), 64'd1);
          check("crit_valid", 64'(io.crit_valid), 64'(e.crit));
          if (e.crit) check("crit_data", io.crit_data, e.data);
        end
      end else begin
        check("crit_idle", 64'(io.crit_valid), 64'd0);
      end
      if (io.done || (cyc == exp_done)) begin
        check("done_pulse", 64'(io.done), 64'd1);
        check("done_cycle", 64'(cyc), 64'(exp_done));
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_ready"}, 64'(io.req_ready), 64'd1);
    check({tag, "_ctl"}, 64'({io.bus_rd_valid, io.bus_data_ready, io.mem_en, io.rd_wr,
                              io.crit_valid, io.done, io.busy, io.way_index}), 64'd0);
    check({tag, "_addr"}, {io.addr, io.bus_rd_addr}, 64'd0);
    check({tag, "_data"}, io.data_in, 64'd0);
    check({tag, "_crit_data"}, io.crit_data, 64'd0);
  endtask

  task automatic run_txn(input logic [31:0] a, input logic [2:0] w, input bit presented,
                         input bit stall, input int vpat, input bit busy, input bit rmode,
                         input bit extra, input logic [31:0] na, input logic [2:0] nw);
    logic [31:0] exp_rd;
    logic [63:0] d;
    logic [2:0]  widx;
    int          start;
    int          k;
    int          n;
    int          guard;
    bit          v;
`ifdef REFILL_CRIT_FIRST_EN
    start  = int'(a[5:3]);
    exp_rd = {a[31:3], 3'b000};
`else
    start  = 0;
    exp_rd = {a[31:6], 6'b000000};
`endif
    if (!presented) begin
      @(posedge clk); #1;
      io.req_valid = 1'b1;
      io.req_addr  = a;
      io.req_way   = w;
    end
    guard = 0;
    @(negedge clk);
    while (!io.req_ready && guard < 50) begin
      guard++;
      @(negedge clk);
    end
    check("req_ready_wait", 64'(io.req_ready), 64'd1);
    if (presented) check("req_after_done", 64'(cyc), 64'(last_done + 1));
    @(posedge clk); #1;
    // Scramble request inputs after acceptance: the engine must hold its latched copy
    io.req_valid = 1'b0;
    io.req_addr  = $urandom();
    io.req_way   = 3'($urandom_range(0, 7));

    n = stall ? $urandom_range(1, 3) : 0;
    for (int i = 0; i <= n; i++) begin
      io.bus_rd_ready   = (i == n);
      io.bus_data_valid = 1'($urandom_range(0, 1));
      io.bus_data       = {$urandom(), $urandom()};
      @(negedge clk);
      check("rd_valid", 64'(io.bus_rd_valid), 64'd1);
      check("rd_addr", 64'(io.bus_rd_addr), 64'(exp_rd));
      check("data_ready_req", 64'(io.bus_data_ready), 64'd0);
      check("busy_req", 64'(io.busy), 64'd1);
      check("req_ready_req", 64'(io.req_ready), 64'd0);
      @(posedge clk); #1;
    end
    io.bus_rd_ready = 1'b0;

    if (busy) begin
      io.req_valid = 1'b1;
      io.req_addr  = na;
      io.req_way   = nw;
    end
    k = 0;
    guard = 0;
    while (k < 8 && guard < 200) begin
      guard++;
      v = (vpat == 0) ? 1'b1 : (vpat == 1) ? ((guard % 2) == 1) : ($urandom_range(0, 3) != 0);
      d = {$urandom(), $urandom()};
      io.bus_data_valid = v;
      io.bus_data       = d;
      @(negedge clk);
      check("data_ready_fill", 64'(io.bus_data_ready), 64'd1);
      if (busy) check("req_ready_fill", 64'(io.req_ready), 64'd0);
      if (v) begin
        widx = 3'((start + k) % 8);
        wr_q.push_back('{cyc + 1, {3'b000, a[31:6], widx}, d, w, (widx == a[5:3])});
        k++;
        if (k == 8) begin
          exp_done  = cyc + 2;
          last_done = cyc + 2;
        end
      end
      if (rmode && k == 4) break;
      @(posedge clk); #1;
    end
    check("beats_sent", 64'(k), rmode ? 64'd4 : 64'd8);

    if (rmode) begin
      @(posedge clk); #1;
      rst = 1'b0;
      io.bus_data_valid = 1'b0;
      wr_q.delete();
      exp_done = -1;
      #1;
      check_reset_outputs("rst_mid");
      @(negedge clk);
      check_reset_outputs("rst_hold");
      @(posedge clk); #1;
      rst = 1'b1;
      return;
    end

    io.bus_data_valid = extra;
    io.bus_data       = {$urandom(), $urandom()};
    @(negedge clk);
    check("data_ready_last_wr", 64'(io.bus_data_ready), 64'd0);
    check("busy_last_wr", 64'(io.busy), 64'd1);
    @(posedge clk); #1;
    @(negedge clk);
    check("data_ready_done", 64'(io.bus_data_ready), 64'd0);
    check("req_ready_done", 64'(io.req_ready), 64'd0);
    io.bus_data_valid = 1'b0;
  endtask

  logic [31:0] ta[N_TXN];
  logic [2:0]  tw[N_TXN];
  bit          t_stall[N_TXN];
  int          t_vpat[N_TXN];
  bit          t_busy[N_TXN];
  bit          t_rst[N_TXN];
  bit          t_extra[N_TXN];

  initial begin
    rst               = 1'b0;
    io.req_valid      = 1'b0;
    io.req_addr       = '0;
    io.req_way        = '0;
    io.bus_rd_ready   = 1'b0;
    io.bus_data_valid = 1'b0;
    io.bus_data       = '0;

    for (int i = 0; i < int'(N_TXN); i++) begin
      ta[i]      = $urandom();
      tw[i]      = 3'($urandom_range(0, 7));
      t_stall[i] = 1'($urandom_range(0, 1));
      t_vpat[i]  = $urandom_range(0, 2);
      t_busy[i]  = ($urandom_range(0, 3) == 0);
      t_rst[i]   = !t_busy[i] && ($urandom_range(0, 5) == 0);
      t_extra[i] = 1'($urandom_range(0, 1));
    end
    // Directed front: basic, wrap, stalls, busy request, mid-fill reset, extra beat
    ta[0] = 32'h0000_1240; tw[0] = 3'd5;
    t_stall[0] = 1'b0; t_vpat[0] = 0; t_busy[0] = 1'b0; t_rst[0] = 1'b0; t_extra[0] = 1'b0;
    ta[1] = ta[1] | 32'h0000_0038;
    t_stall[1] = 1'b0; t_vpat[1] = 0; t_busy[1] = 1'b0; t_rst[1] = 1'b0;
    t_stall[2] = 1'b1; t_vpat[2] = 1; t_busy[2] = 1'b0; t_rst[2] = 1'b0;
    t_busy[3]  = 1'b1; t_rst[3] = 1'b0;
    t_busy[5]  = 1'b0; t_rst[5] = 1'b1; t_vpat[5] = 0;
    t_busy[6]  = 1'b0; t_rst[6] = 1'b0; t_extra[6] = 1'b1; t_vpat[6] = 0;
    t_busy[N_TXN-1] = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("rst_init");
    rst = 1'b1;

    for (int i = 0; i < int'(N_TXN); i++) begin
      run_txn(ta[i], tw[i], (i > 0) && t_busy[i-1], t_stall[i], t_vpat[i], t_busy[i],
              t_rst[i], t_extra[i],
              (i + 1 < int'(N_TXN)) ? ta[i+1] : 32'h0,
              (i + 1 < int'(N_TXN)) ? tw[i+1] : 3'h0);
    end

    repeat (5) @(negedge clk);
    check("writes_drained", 64'(wr_q.size()), 64'd0);
    check("idle_at_end", 64'(io.req_ready), 64'd1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached (cycle %0d)", cyc);
    $fatal(1);
  end

endmodule
